mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive LSU wins while fetch is waiting (range 1..7).
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_if_req  in  1  fetch request; i_if_addr  in  32  fetch byte address.
REQ-005 i_if_flush  in  1  discard the outstanding or incoming fetch (branch/jump taken).
REQ-006 o_if_gnt  out  1  fetch accepted; o_if_rvalid  out  1  fetch data valid; o_if_rdata  out  32  instruction word.
REQ-007 i_lsu_req  in  1  data request; i_lsu_we  in  1  write enable; i_lsu_addr  in  32  address; i_lsu_wdata  in  32  write data; i_lsu_bmask  in  4  byte mask.
REQ-008 o_lsu_gnt  out  1  data request accepted; o_lsu_rvalid  out  1  data transaction complete; o_lsu_rdata  out  32  load data.
REQ-009 o_mem_req  out  1; o_mem_we  out  1; o_mem_addr  out  32; o_mem_wdata  out  32; o_mem_bmask  out  4: single shared memory port.
REQ-010 i_mem_ack  in  1  memory completes current access; i_mem_rdata  in  32  read data, valid with ack.
REQ-011 o_busy  out  1  a transaction is outstanding.

Function
REQ-012 SHALL implement FSM IDLE, BUSY_IF, BUSY_LSU; at most one outstanding memory transaction.
REQ-013 In IDLE, grant is combinational: o_*_gnt asserted in the same cycle as the winning request; no grant is issued in BUSY states.
REQ-014 Priority in IDLE: LSU wins over fetch, except fetch wins when the starvation counter equals STARVE_MAX.
REQ-015 Fetch is not granted in a cycle where i_if_flush=1.
REQ-016 On grant, requester's address, we, wdata and bmask (fetch: we=0, bmask=4'hF, wdata=0) are registered; FSM enters BUSY_IF/BUSY_LSU next cycle.
REQ-017 In BUSY states, o_mem_req=1 and the registered fields hold stable until the cycle i_mem_ack=1.
REQ-018 On ack: FSM returns to IDLE next cycle; the owner's rvalid pulses one cycle in that next cycle; rdata = registered i_mem_rdata (LSU write: rdata=0, rvalid still pulses).
REQ-019 Minimum latency: gnt at cycle T, o_mem_req at T+1, ack earliest at T+1, rvalid at T+2; a new grant is allowed in the rvalid cycle.
REQ-020 i_mem_ack while IDLE SHALL be ignored.
REQ-021 A flush asserted at any cycle from fetch grant through the ack cycle marks the fetch killed; the memory access still completes but o_if_rvalid is suppressed.
REQ-022 Starvation counter (3 bits): increments, saturating at STARVE_MAX, on each LSU grant with i_if_req=1 and i_if_flush=0; clears on any fetch grant, or in an IDLE cycle with i_if_req=0.
REQ-023 o_busy = 1 in BUSY_IF/BUSY_LSU, 0 in IDLE.
REQ-024 Unused rdata outputs SHALL hold their last value; only rvalid qualifies them.

Reset
REQ-025 While i_rst=1: FSM=IDLE, starvation counter=0, kill flag=0, all o_* outputs 0, no grants.
REQ-026 Reset during BUSY aborts the transaction: o_mem_req=0 the cycle after reset is sampled; no rvalid is produced for the aborted access, even if i_mem_ack arrives.

Verification
REQ-027 Fetch only: i_if_req=1, addr=0x100, ack 1 cycle after o_mem_req, rdata=0x00500093 -> gnt T, mem_req T+1 with addr 0x100, o_if_rvalid T+2 with rdata 0x00500093.
REQ-028 Simultaneous fetch 0x104 and LSU load 0x2000 -> LSU granted first; fetch granted in the LSU rvalid cycle.
REQ-029 Starvation: i_lsu_req and i_if_req both held high, STARVE_MAX=4 -> 4 LSU grants, then 1 fetch grant, then the counter clears.
REQ-030 Flush: fetch granted; i_if_flush pulsed at T+1; ack at T+3 -> o_mem_req held T+1..T+3, no o_if_rvalid, IDLE at T+4.
REQ-031 LSU store we=1, addr 0x7000, wdata 0xDEADBEEF, bmask 4'b0011; ack delayed 5 cycles -> o_mem_* stable for all 5 cycles; o_lsu_rvalid once, with rdata=0.
REQ-032 i_rst asserted in BUSY_LSU, ack arriving the next cycle -> no rvalid; all outputs 0; a subsequent fetch works from IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-outstanding memory port between the instruction fetch
// unit and the load/store unit.
// - The grant is combinational in IDLE. LSU normally wins.
// - Fetch wins once the starvation counter reaches STARVE_MAX.
// - A flush seen between the fetch grant and its ack suppresses the fetch rvalid.
//
// Ports
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_if_req/i_if_addr/i_if_flush     fetch request, byte address, flush/kill
//   o_if_gnt/o_if_rvalid/o_if_rdata   fetch grant, data valid, instruction
//   i_lsu_req/we/addr/wdata/bmask     data request fields
//   o_lsu_gnt/o_lsu_rvalid/o_lsu_rdata  data grant, completion, load data
//   o_mem_req/we/addr/wdata/bmask     shared memory port (held until ack)
//   i_mem_ack/i_mem_rdata             memory completion and read data
//   o_busy                            a transaction is outstanding
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_lsu_req,
    input  logic        i_lsu_we,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    input  logic [3:0]  i_lsu_bmask,
    output logic        o_lsu_gnt,
    output logic        o_lsu_rvalid,
    output logic [31:0] o_lsu_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_LSU = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      r_state;
    state_t      w_next;
    logic        w_if_gnt;
    logic        w_lsu_gnt;
    logic        w_fetch_ok;
    logic [2:0]  r_starve;
    logic        r_kill;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_bmask;
    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_lsu_rvalid;
    logic [31:0] r_lsu_rdata;

    // A flushed fetch is never eligible, so a flush cycle cannot win fetch priority.
    assign w_fetch_ok = i_if_req & ~i_if_flush;

    // Next-state and combinational grant selection
    always_comb begin
        w_next    = r_state;
        w_if_gnt  = 1'b0;
        w_lsu_gnt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rst) begin
                    w_next = ST_IDLE;
                end else if (w_fetch_ok && (!i_lsu_req || (r_starve == STARVE_LIM))) begin
                    w_if_gnt = 1'b1;
                    w_next   = ST_BUSY_IF;
                end else if (i_lsu_req) begin
                    w_lsu_gnt = 1'b1;
                    w_next    = ST_BUSY_LSU;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_BUSY_IF, ST_BUSY_LSU: begin
                if (i_mem_ack) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = r_state;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the winning requester's fields; they drive the memory port until ack
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we    <= 1'b0;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
            r_bmask <= 4'h0;
        end else if (w_if_gnt) begin
            r_we    <= 1'b0;
            r_addr  <= i_if_addr;
            r_wdata <= 32'h0000_0000;
            r_bmask <= 4'hF;
        end else if (w_lsu_gnt) begin
            r_we    <= i_lsu_we;
            r_addr  <= i_lsu_addr;
            r_wdata <= i_lsu_wdata;
            r_bmask <= i_lsu_bmask;
        end else begin
            r_we    <= r_we;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
            r_bmask <= r_bmask;
        end
    end

    // Fetch kill flag: a flush any time during the fetch marks it dead
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_kill <= 1'b0;
        end else if ((r_state == ST_BUSY_IF) && !i_mem_ack) begin
            r_kill <= r_kill | i_if_flush;
        end else begin
            r_kill <= 1'b0;
        end
    end

    // Response capture: one-cycle rvalid after ack, rdata held otherwise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= 32'h0000_0000;
            r_lsu_rvalid <= 1'b0;
            r_lsu_rdata  <= 32'h0000_0000;
        end else begin
            r_if_rvalid  <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            case (r_state)
                ST_BUSY_IF: begin
                    // The ack-cycle flush counts as well, so it is ORed in here.
                    if (i_mem_ack && !(r_kill || i_if_flush)) begin
                        r_if_rvalid <= 1'b1;
                        r_if_rdata  <= i_mem_rdata;
                    end else begin
                        r_if_rdata  <= r_if_rdata;
                    end
                end
                ST_BUSY_LSU: begin
                    if (i_mem_ack) begin
                        r_lsu_rvalid <= 1'b1;
                        r_lsu_rdata  <= r_we ? 32'h0000_0000 : i_mem_rdata;
                    end else begin
                        r_lsu_rdata  <= r_lsu_rdata;
                    end
                end
                default: begin
                    r_if_rdata  <= r_if_rdata;
                    r_lsu_rdata <= r_lsu_rdata;
                end
            endcase
        end
    end

    // Starvation counter: counts LSU wins taken while fetch was eligible
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve <= 3'd0;
        end else if (w_if_gnt) begin
            r_starve <= 3'd0;
        end else if (w_lsu_gnt && w_fetch_ok) begin
            r_starve <= (r_starve >= STARVE_LIM) ? STARVE_LIM : r_starve + 3'd1;
        end else if ((r_state == ST_IDLE) && !i_if_req) begin
            r_starve <= 3'd0;
        end else begin
            r_starve <= r_starve;
        end
    end

    assign o_if_gnt     = w_if_gnt;
    assign o_lsu_gnt    = w_lsu_gnt;
    assign o_if_rvalid  = r_if_rvalid;
    assign o_if_rdata   = r_if_rdata;
    assign o_lsu_rvalid = r_lsu_rvalid;
    assign o_lsu_rdata  = r_lsu_rdata;
    assign o_mem_req    = (r_state != ST_IDLE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_mem_we     = r_we;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;
    assign o_mem_bmask  = r_bmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter. Inputs change 1 time unit after the
// rising edge. Outputs are sampled 1 time unit later, within the same cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        i_if_flush;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_lsu_req;
    logic        i_lsu_we;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_lsu_wdata;
    logic [3:0]  i_lsu_bmask;
    logic        o_lsu_gnt;
    logic        o_lsu_rvalid;
    logic [31:0] o_lsu_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we), .i_lsu_addr(i_lsu_addr),
        .i_lsu_wdata(i_lsu_wdata), .i_lsu_bmask(i_lsu_bmask),
        .o_lsu_gnt(o_lsu_gnt), .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rdata(o_lsu_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
    );

    // 10-unit clock
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge (input drive point)
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_if_req = 1'b1; i_if_addr = 32'h0000_0040; i_if_flush = 1'b0;
        i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 32'h0000_0080;
        i_lsu_wdata = 32'h0000_0000; i_lsu_bmask = 4'hF;
        i_mem_ack = 1'b0; i_mem_rdata = 32'h0000_0000;

        // ---- reset: no grants, outputs zero ----
        step(); step(); settle();
        check_eq("rst_if_gnt",  {31'd0, o_if_gnt},  32'd0);
        check_eq("rst_lsu_gnt", {31'd0, o_lsu_gnt}, 32'd0);
        check_eq("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        check_eq("rst_busy",    {31'd0, o_busy},    32'd0);
        check_eq("rst_mem_addr", o_mem_addr,        32'd0);
        i_rst = 1'b0; i_if_req = 1'b0; i_lsu_req = 1'b0;
        step();

        // ---- ack while IDLE is ignored ----
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
        step(); i_mem_ack = 1'b0; settle();
        check_eq("idle_ack_busy",   {31'd0, o_busy},       32'd0);
        check_eq("idle_ack_ifrv",   {31'd0, o_if_rvalid},  32'd0);
        check_eq("idle_ack_lsurv",  {31'd0, o_lsu_rvalid}, 32'd0);

        // ---- fetch only ----
        i_if_req = 1'b1; i_if_addr = 32'h0000_0100; settle();
        check_eq("f_gnt", {31'd0, o_if_gnt}, 32'd1);
        step(); i_if_req = 1'b0; settle();
        check_eq("f_mem_req",  {31'd0, o_mem_req}, 32'd1);
        check_eq("f_mem_addr", o_mem_addr,         32'h0000_0100);
        check_eq("f_mem_we",   {31'd0, o_mem_we},  32'd0);
        check_eq("f_bmask",    {28'd0, o_mem_bmask}, 32'hF);
        check_eq("f_busy",     {31'd0, o_busy},    32'd1);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0050_0093;
        step(); i_mem_ack = 1'b0; settle();
        check_eq("f_rvalid",   {31'd0, o_if_rvalid}, 32'd1);
        check_eq("f_rdata",    o_if_rdata,           32'h0050_0093);
        check_eq("f_idle",     {31'd0, o_busy},      32'd0);
        step(); settle();
        check_eq("f_rvalid_pulse", {31'd0, o_if_rvalid}, 32'd0);
        check_eq("f_rdata_hold",   o_if_rdata,           32'h0050_0093);

        // ---- simultaneous fetch + LSU load ----
        i_if_req = 1'b1; i_if_addr = 32'h0000_0104;
        i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 32'h0000_2000; settle();
        check_eq("s_lsu_gnt", {31'd0, o_lsu_gnt}, 32'd1);
        check_eq("s_if_gnt0", {31'd0, o_if_gnt},  32'd0);
        step(); i_lsu_req = 1'b0; settle();
        check_eq("s_mem_addr",    o_mem_addr,        32'h0000_2000);
        check_eq("s_busy_no_gnt", {31'd0, o_if_gnt}, 32'd0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1122_3344;
        step(); i_mem_ack = 1'b0; settle();
        check_eq("s_lsu_rvalid", {31'd0, o_lsu_rvalid}, 32'd1);
        check_eq("s_lsu_rdata",  o_lsu_rdata,           32'h1122_3344);
        check_eq("s_if_gnt",     {31'd0, o_if_gnt},     32'd1);
        step(); i_if_req = 1'b0; settle();
        check_eq("s_if_addr", o_mem_addr, 32'h0000_0104);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0013;
        step(); i_mem_ack = 1'b0; settle();
        check_eq("s_if_rvalid", {31'd0, o_if_rvalid}, 32'd1);
        check_eq("s_if_rdata",  o_if_rdata,           32'h0000_0013);
        step();

        // ---- starvation: 4 LSU grants, 1 fetch, then LSU again ----
        i_if_req = 1'b1; i_if_addr = 32'h0000_0200;
        i_lsu_req = 1'b1; i_lsu_addr = 32'h0000_3000;
        for (int i = 0; i < 6; i++) begin
            settle();
            check_eq($sformatf("starve_if_gnt%0d", i),  {31'd0, o_if_gnt},  (i == 4) ? 32'd1 : 32'd0);
            check_eq($sformatf("starve_lsu_gnt%0d", i), {31'd0, o_lsu_gnt}, (i == 4) ? 32'd0 : 32'd1);
            step(); i_mem_ack = 1'b1;
            step(); i_mem_ack = 1'b0;
        end
        i_if_req = 1'b0; i_lsu_req = 1'b0;
        step();

        // ---- flush blocks the grant, and a flush in flight kills the fetch ----
        i_if_req = 1'b1; i_if_addr = 32'h0000_0300; i_if_flush = 1'b1; settle();
        check_eq("fl_no_gnt", {31'd0, o_if_gnt}, 32'd0);
        i_if_flush = 1'b0; settle();
        check_eq("fl_gnt", {31'd0, o_if_gnt}, 32'd1);
        step(); i_if_req = 1'b0; i_if_flush = 1'b1; settle();
        check_eq("fl_req_t1", {31'd0, o_mem_req}, 32'd1);
        step(); i_if_flush = 1'b0; settle();
        check_eq("fl_req_t2", {31'd0, o_mem_req}, 32'd1);
        step(); i_mem_ack = 1'b1; i_mem_rdata = 32'hAAAA_5555; settle();
        check_eq("fl_req_t3", {31'd0, o_mem_req}, 32'd1);
        step(); i_mem_ack = 1'b0; settle();
        check_eq("fl_no_rvalid", {31'd0, o_if_rvalid}, 32'd0);
        check_eq("fl_idle",      {31'd0, o_busy},      32'd0);
        check_eq("fl_mem_req0",  {31'd0, o_mem_req},   32'd0);

        // ---- LSU store with a slow ack ----
        i_lsu_req = 1'b1; i_lsu_we = 1'b1; i_lsu_addr = 32'h0000_7000;
        i_lsu_wdata = 32'hDEAD_BEEF; i_lsu_bmask = 4'b0011; settle();
        check_eq("st_gnt", {31'd0, o_lsu_gnt}, 32'd1);
        step(); i_lsu_req = 1'b0; i_lsu_we = 1'b0; i_lsu_wdata = 32'h0; i_lsu_bmask = 4'hF;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin
                i_mem_ack = 1'b1; i_mem_rdata = 32'h5555_5555;
            end
            settle();
            check_eq($sformatf("st_req%0d", k),   {31'd0, o_mem_req},   32'd1);
            check_eq($sformatf("st_we%0d", k),    {31'd0, o_mem_we},    32'd1);
            check_eq($sformatf("st_addr%0d", k),  o_mem_addr,           32'h0000_7000);
            check_eq($sformatf("st_wdata%0d", k), o_mem_wdata,          32'hDEAD_BEEF);
            check_eq($sformatf("st_bmask%0d", k), {28'd0, o_mem_bmask}, 32'h3);
            check_eq($sformatf("st_rv%0d", k),    {31'd0, o_lsu_rvalid}, 32'd0);
            step();
        end
        i_mem_ack = 1'b0; settle();
        check_eq("st_rvalid", {31'd0, o_lsu_rvalid}, 32'd1);
        check_eq("st_rdata",  o_lsu_rdata,           32'h0000_0000);
        step(); settle();
        check_eq("st_rvalid_once", {31'd0, o_lsu_rvalid}, 32'd0);

        // ---- reset during BUSY_LSU aborts the access ----
        i_lsu_req = 1'b1; i_lsu_addr = 32'h0000_4000; settle();
        check_eq("ra_gnt", {31'd0, o_lsu_gnt}, 32'd1);
        step(); i_lsu_req = 1'b0; i_rst = 1'b1; settle();
        check_eq("ra_busy_before", {31'd0, o_busy}, 32'd1);
        step(); i_rst = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h9999_9999; settle();
        check_eq("ra_mem_req0", {31'd0, o_mem_req}, 32'd0);
        check_eq("ra_busy0",    {31'd0, o_busy},    32'd0);
        check_eq("ra_addr0",    o_mem_addr,         32'd0);
        check_eq("ra_if_rdata0", o_if_rdata,        32'd0);
        step(); i_mem_ack = 1'b0; settle();
        check_eq("ra_no_rvalid", {31'd0, o_lsu_rvalid}, 32'd0);
        i_if_req = 1'b1; i_if_addr = 32'h0000_0400; settle();
        check_eq("ra_f_gnt", {31'd0, o_if_gnt}, 32'd1);
        step(); i_if_req = 1'b0; settle();
        check_eq("ra_f_addr", o_mem_addr, 32'h0000_0400);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0517;
        step(); i_mem_ack = 1'b0; settle();
        check_eq("ra_f_rvalid", {31'd0, o_if_rvalid}, 32'd1);
        check_eq("ra_f_rdata",  o_if_rdata,           32'h0000_0517);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
